// File: rtl/decode_stage_buf_if.sv
// Fetch->decode->execute handshake bundle for the decode stage buffer.
// master: upstream fetch / downstream execute side; slave: the buffer.
interface decode_stage_buf_if #(
  parameter int ISC_BIT = 32,
  parameter int ADR_BIT = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [ISC_BIT-1:0] isc;
  logic [ADR_BIT-1:0] pc_next_in;
  logic               out_valid;
  logic               out_ready;
  logic [5:0]         op;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [4:0]         shamt;
  logic [5:0]         rfunct;
  logic [15:0]        imm;
  logic [ADR_BIT-1:0] imm_ext;
  logic [25:0]        jaddr;
  logic [5:0]         real_op;
  logic [ADR_BIT-1:0] pc_next;

  modport master (
    output in_valid, isc, pc_next_in, out_ready,
    input  in_ready, out_valid, op, rs, rt, rd, shamt, rfunct,
           imm, imm_ext, jaddr, real_op, pc_next
  );

  modport slave (
    input  in_valid, isc, pc_next_in, out_ready,
    output in_ready, out_valid, op, rs, rt, rd, shamt, rfunct,
           imm, imm_ext, jaddr, real_op, pc_next
  );
endinterface

// File: rtl/decode_stage_buf.sv
// Decode stage buffer: decodes MIPS-style instructions on entry and holds
// them in a small circular FIFO. Flush kills everything (buffered and
// incoming) and the killed entries are tallied in a saturating counter.
module decode_stage_buf #(
  parameter int ISC_BIT = 32,
  parameter int ADR_BIT = 32,
  parameter int DEPTH   = 2,
  parameter int CNT_BIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  decode_stage_buf_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_BIT-1:0]     drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  // drop_cnt + count + 1 never exceeds 2^CNT_BIT + 8, so 5 extra bits suffice
  localparam int SW = CNT_BIT + 5;
  localparam logic [SW-1:0] SAT = SW'({CNT_BIT{1'b1}});

  typedef struct packed {
    logic [5:0]         op;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic [5:0]         rfunct;
    logic [15:0]        imm;
    logic [ADR_BIT-1:0] imm_ext;
    logic [25:0]        jaddr;
    logic [5:0]         real_op;
    logic [ADR_BIT-1:0] pc_next;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          wr_ent;
  ent_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          acc;
  logic          push;
  logic          pop;
  logic [SW-1:0] drop_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode the incoming instruction into its stored form
  always_comb begin
    wr_ent         = '0;
    wr_ent.op      = bus.isc[31:26];
    wr_ent.rs      = bus.isc[25:21];
    wr_ent.rt      = bus.isc[20:16];
    wr_ent.rd      = bus.isc[15:11];
    wr_ent.shamt   = bus.isc[10:6];
    wr_ent.rfunct  = bus.isc[5:0];
    wr_ent.imm     = bus.isc[15:0];
    wr_ent.jaddr   = bus.isc[25:0];
    wr_ent.pc_next = bus.pc_next_in;
    // R-type instructions carry their real operation in the funct field
    wr_ent.real_op = (bus.isc[31:26] == 6'h00) ? bus.isc[5:0] : bus.isc[31:26];
    // logical immediates (andi/ori/xori) zero-extend, everything else sign-extends
    if (bus.isc[31:26] inside {6'h0C, 6'h0D, 6'h0E})
      wr_ent.imm_ext = {{(ADR_BIT-16){1'b0}}, bus.isc[15:0]};
    else
      wr_ent.imm_ext = {{(ADR_BIT-16){bus.isc[15]}}, bus.isc[15:0]};
  end

  // No pass-through when full: readiness depends only on current occupancy
  assign bus.in_ready  = rst_n & (count < FULL);
  assign bus.out_valid = (count != '0);
  assign acc           = bus.in_valid & bus.in_ready;
  assign push          = acc & ~flush;
  assign pop           = bus.out_valid & bus.out_ready & ~flush;
  assign drop_sum      = SW'(drop_cnt) + SW'(count) + SW'(acc);

  // Pointer, occupancy, storage and drop-counter update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= (drop_sum > SAT) ? '1 : drop_sum[CNT_BIT-1:0];
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Present the head entry; stale storage is masked to zero when empty
  always_comb begin
    head = '0;
    if (bus.out_valid) head = mem[rd_ptr];
  end

  assign bus.op      = head.op;
  assign bus.rs      = head.rs;
  assign bus.rt      = head.rt;
  assign bus.rd      = head.rd;
  assign bus.shamt   = head.shamt;
  assign bus.rfunct  = head.rfunct;
  assign bus.imm     = head.imm;
  assign bus.imm_ext = head.imm_ext;
  assign bus.jaddr   = head.jaddr;
  assign bus.real_op = head.real_op;
  assign bus.pc_next = head.pc_next;
endmodule

// File: doc/decode_stage_buf.md
DECODE_STAGE_BUF -- requirements
Module: decode_stage_buf

Parameters
REQ-001 SHALL have parameter ISC_BIT, default 32, instruction width (MIPS-style field layout, fixed bit positions).
REQ-002 SHALL have parameter ADR_BIT, default 32, PC width.
REQ-003 SHALL have parameter DEPTH, default 2, decoded-entry buffer depth; legal values 2, 4, 8.
REQ-004 SHALL have parameter CNT_BIT, default 8, width of the flush-drop statistics counter.

Interface
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-006 flush in 1: branch-taken kill; discards all buffered and same-cycle incoming entries.
REQ-007 in_valid in 1 / in_ready out 1: upstream fetch handshake.
REQ-008 isc in ISC_BIT: raw instruction.
REQ-009 pc_next_in in ADR_BIT: PC+4 of isc.
REQ-010 out_valid out 1 / out_ready in 1: downstream execute handshake.
REQ-011 op out 6, rs out 5, rt out 5, rd out 5, shamt out 5, rfunct out 6: decoded fields of the head entry.
REQ-012 imm out 16 = isc[15:0]; imm_ext out ADR_BIT: extended immediate.
REQ-013 jaddr out 26 = isc[25:0]: jump target field.
REQ-014 real_op out 6: effective opcode.
REQ-015 pc_next out ADR_BIT: pc_next_in of the head entry.
REQ-016 count out clog2(DEPTH)+1: number of occupied entries.
REQ-017 drop_cnt out CNT_BIT: entries killed by flush, saturating.

Function
REQ-018 SHALL hold entries in a circular buffer (wr_ptr, rd_ptr, count); pointers wrap from DEPTH-1 to 0.
REQ-019 in_ready SHALL be 1 iff count < DEPTH and rst_n=1; no pass-through when full, even if a pop occurs in the same cycle.
REQ-020 push SHALL occur on in_valid & in_ready & ~flush: decode isc and store all fields plus pc_next_in at wr_ptr.
REQ-021 out_valid SHALL be 1 iff count > 0; output fields SHALL show the entry at rd_ptr; all fields SHALL read 0 when count = 0.
REQ-022 pop SHALL occur on out_valid & out_ready & ~flush; rd_ptr advances.
REQ-023 Latency: an instruction pushed at edge N SHALL appear on the outputs with out_valid=1 after edge N when the buffer was empty (one cycle).
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 real_op SHALL equal isc[5:0] when isc[31:26]=0, otherwise isc[31:26].
REQ-026 imm_ext SHALL be isc[15:0] zero-extended when op is 6'h0C, 6'h0D or 6'h0E (andi/ori/xori), otherwise sign-extended from bit 15.
REQ-027 flush SHALL have priority over push and pop: at the edge, count and pointers become 0, and the same-cycle push is discarded.
REQ-028 On flush, drop_cnt SHALL increase by count plus 1 if in_valid & in_ready, saturating at 2^CNT_BIT-1.
REQ-029 Entries SHALL be emitted in strict FIFO order; no entry may be duplicated or lost except by flush.

Reset
REQ-030 With rst_n=0 at a rising edge: count, wr_ptr, rd_ptr and drop_cnt SHALL become 0; all stored entries SHALL become 0; out_valid=0; in_ready=0 while rst_n=0.
REQ-031 Reset SHALL override flush, push and pop in the same cycle; reset mid-stream discards buffered entries without changing drop_cnt (it is cleared).

Verification
REQ-032 Reset, then push isc=32'h012A4020 (add) with pc_next_in=32'h4 -> next cycle: out_valid=1, op=0, rs=9, rt=10, rd=8, rfunct=6'h20, real_op=6'h20, pc_next=32'h4.
REQ-033 Push isc=32'h3508FFFF (ori) -> imm_ext=32'h0000FFFF; push isc=32'h2108FFFF (addi) -> imm_ext=32'hFFFFFFFF, real_op=6'h08.
REQ-034 Hold out_ready=0 and push DEPTH=2 entries -> count=2, in_ready=0; a third in_valid is not accepted; raise out_ready -> entries drain in order and in_ready returns to 1 the cycle after the first pop.
REQ-035 With count=2 and in_valid=1, assert flush for one cycle -> next cycle: count=0, out_valid=0, drop_cnt=2 (the incoming entry is not counted because in_ready=0).
REQ-036 Continuous push and pop with out_ready=1 for 20 instructions -> count stays 1, output order matches input order, and the pointers wrap correctly.
REQ-037 Assert rst_n=0 with count=1 and flush=1 -> next cycle: all outputs 0 and drop_cnt=0.
